// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the accumulator ALU sequencer: data/opcode widths,
// opcode encodings, controller state encoding and opcode class helpers.
package alu_sequencer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR = 3'b010;
  localparam logic [OP_W-1:0] OP_SHL = 3'b011;
  localparam logic [OP_W-1:0] OP_LDA = 3'b100;
  localparam logic [OP_W-1:0] OP_STA = 3'b101;
  localparam logic [OP_W-1:0] OP_CMA = 3'b110;
  localparam logic [OP_W-1:0] OP_CLA = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_EXEC = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Opcodes that fetch an operand from memory before retiring or executing.
  function automatic logic op_reads_mem(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

  // Opcodes that go straight to the ALU without touching memory.
  function automatic logic op_is_unary(input logic [OP_W-1:0] op);
    return (op == OP_SHL) || (op == OP_CMA) || (op == OP_CLA);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle accumulator controller sequencing an external 8-bit ALU.
// Owns AC, DR and the E (carry) flag; accepts one instruction at a time,
// fetches operands / stores AC over a wait-state memory port and latches
// the ALU result.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/ready        instruction handshake (ready only in IDLE)
//   instr_op, instr_addr     opcode and operand/store address
//   mem_req/we/addr/wdata    memory request, held until mem_ack
//   mem_rdata, mem_ack       load data and access completion
//   alu_sel, alu_ac, alu_dr  ALU selector and operand registers
//   alu_result               combinational ALU result
//   ac_out, e_out            architectural AC and E
//   done                     one-cycle retire pulse
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [OP_W-1:0]   alu_sel,
  output logic [DATA_W-1:0] alu_ac,
  output logic [DATA_W-1:0] alu_dr,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] ac_out,
  output logic              e_out,
  output logic              done
);

  state_t              r_state;
  state_t              w_state_n;
  logic                w_accept;
  logic [OP_W-1:0]     w_op_n;

  logic [OP_W-1:0]     r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_ac;
  logic [DATA_W-1:0]   r_dr;
  logic                r_e;

  logic                r_mem_req;
  logic                r_mem_we;
  logic [OP_W-1:0]     r_alu_sel;
  logic                r_ready;
  logic                r_done;

  logic [DATA_W:0]     w_add;
  logic [DATA_W:0]     w_sub;
  logic                w_e_n;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state logic; acceptance is only possible in IDLE.
  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (instr_valid) begin
          w_accept = 1'b1;
          if (op_reads_mem(instr_op)) begin
            w_state_n = ST_RD;
          end else if (op_is_unary(instr_op)) begin
            w_state_n = ST_EXEC;
          end else begin
            w_state_n = ST_WR;
          end
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          w_state_n = (r_op == OP_LDA) ? ST_DONE : ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_n = ST_DONE;
      end
      ST_WR: begin
        if (mem_ack) begin
          w_state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_n = ST_IDLE;
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // Opcode in effect next cycle, so alu_sel can be registered into EXEC.
  assign w_op_n = w_accept ? instr_op : r_op;

  // 9-bit sums used only for the carry flag; the ALU produces the data result.
  assign w_add = {1'b0, r_ac} + {1'b0, r_dr};
  assign w_sub = {1'b0, r_ac} + {1'b0, ~r_dr} + (DATA_W + 1)'(1);

  always_comb begin
    w_e_n = r_e;
    unique case (r_op)
      OP_ADD:  w_e_n = w_add[DATA_W];
      OP_SUB:  w_e_n = w_sub[DATA_W];
      OP_SHL:  w_e_n = r_ac[DATA_W-1];
      OP_CLA:  w_e_n = 1'b0;
      default: w_e_n = r_e;
    endcase
  end

  // Datapath registers: latched instruction, AC, DR, E.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= OP_ADD;
      r_addr <= '0;
      r_ac   <= '0;
      r_dr   <= '0;
      r_e    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= instr_op;
        r_addr <= instr_addr;
      end
      if ((r_state == ST_RD) && mem_ack) begin
        if (r_op == OP_LDA) begin
          r_ac <= mem_rdata;
        end else begin
          r_dr <= mem_rdata;
        end
      end
      if (r_state == ST_EXEC) begin
        r_ac <= alu_result;
        r_e  <= w_e_n;
      end
    end
  end

  // Control outputs registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_alu_sel <= '0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_mem_req <= (w_state_n == ST_RD) || (w_state_n == ST_WR);
      r_mem_we  <= (w_state_n == ST_WR);
      r_alu_sel <= (w_state_n == ST_EXEC) ? w_op_n : '0;
      r_ready   <= (w_state_n == ST_IDLE);
      r_done    <= (w_state_n == ST_DONE);
    end
  end

  assign instr_ready = r_ready;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_ac;
  assign alu_sel     = r_alu_sel;
  assign alu_ac      = r_ac;
  assign alu_dr      = r_dr;
  assign ac_out      = r_ac;
  assign e_out       = r_e;
  assign done        = r_done;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: ALU and memory responder models,
// reference AC/E model with a scoreboard of expected retire results.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid;
  logic              instr_ready;
  logic [OP_W-1:0]   instr_op;
  logic [ADDR_W-1:0] instr_addr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic [OP_W-1:0]   alu_sel;
  logic [7:0]        alu_ac;
  logic [7:0]        alu_dr;
  logic [7:0]        alu_result;
  logic [7:0]        ac_out;
  logic              e_out;
  logic              done;

  always #5 clk = ~clk;

  alu_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_addr(instr_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_sel(alu_sel), .alu_ac(alu_ac), .alu_dr(alu_dr),
    .alu_result(alu_result), .ac_out(ac_out), .e_out(e_out), .done(done)
  );

  // External ALU.
  always_comb begin
    alu_result = 8'h00;
    case (alu_sel)
      OP_ADD:  alu_result = alu_ac + alu_dr;
      OP_SUB:  alu_result = alu_ac - alu_dr;
      OP_XOR:  alu_result = alu_ac ^ alu_dr;
      OP_SHL:  alu_result = alu_ac + alu_ac;
      OP_CMA:  alu_result = ~alu_ac;
      OP_CLA:  alu_result = 8'h00;
      default: alu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [7:0] ac;
    logic       e;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [256];
  logic [7:0] m_ac;
  logic       m_e;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations from the last instruction run.
  int         obs_req_cycles;
  int         obs_sel_cycles;
  int         obs_busy_ready;
  bit         obs_addr_moved;
  bit         obs_we_low;
  logic [7:0] obs_wdata;

  function automatic int base_lat(input logic [2:0] op);
    if (op == OP_ADD || op == OP_SUB || op == OP_XOR) return 3;
    return 2;
  endfunction

  // Reference update of AC/E for one instruction.
  task automatic model_step(input logic [2:0] op, input logic [7:0] addr);
    int d;
    int s;
    d = int'(mem[addr]);
    case (op)
      OP_LDA: m_ac = mem[addr];
      OP_ADD: begin s = int'(m_ac) + d; m_e = (s > 255); m_ac = 8'(s); end
      OP_SUB: begin m_e = (int'(m_ac) >= d); m_ac = 8'(int'(m_ac) - d + 256); end
      OP_XOR: m_ac = m_ac ^ mem[addr];
      OP_SHL: begin m_e = m_ac[7]; m_ac = 8'(int'(m_ac) * 2); end
      OP_CMA: m_ac = ~m_ac;
      OP_CLA: begin m_ac = 8'h00; m_e = 1'b0; end
      default: ;
    endcase
  endtask

  // Issue one instruction, act as memory with 'waits' wait cycles, retire it.
  task automatic run_instr(input logic [2:0] op, input logic [7:0] addr,
                           input int waits, input bit hold);
    exp_t       x;
    exp_t       got;
    int         lat;
    int         wl;
    logic [7:0] a0;
    bit         seen_req;
    bit         done_seen;
    logic [7:0] sta_exp;
    sta_exp = m_ac;
    model_step(op, addr);
    x.ac  = m_ac;
    x.e   = m_e;
    x.lat = base_lat(op) + ((op == OP_SHL || op == OP_CMA || op == OP_CLA) ? 0 : waits);
    sb.push_back(x);

    instr_valid = 1'b1;
    instr_op    = op;
    instr_addr  = addr;
    n_checks++;
    if (instr_ready !== 1'b1) $display("FAIL ready_before_issue op=%0d: got %b want 1", op, instr_ready);
    else n_pass++;
    @(posedge clk); #1;
    if (hold) instr_op = OP_CLA;
    else instr_valid = 1'b0;

    lat = 1; wl = waits; seen_req = 0; done_seen = 0; a0 = '0;
    obs_req_cycles = 0; obs_sel_cycles = 0; obs_busy_ready = 0;
    obs_addr_moved = 0; obs_we_low = 0; obs_wdata = 8'h00;
    while (lat <= 64) begin
      if (done === 1'b1) begin done_seen = 1; break; end
      if (instr_ready !== 1'b0) obs_busy_ready++;
      if (alu_sel !== 3'b000) obs_sel_cycles++;
      if (mem_req === 1'b1) begin
        if (!seen_req) begin a0 = mem_addr; seen_req = 1; end
        else if (mem_addr !== a0) obs_addr_moved = 1;
        if (op == OP_STA && mem_we !== 1'b1) obs_we_low = 1;
        if (op != OP_STA && mem_we !== 1'b0) obs_we_low = 1;
        obs_req_cycles++;
        if (wl == 0) begin
          mem_ack = 1'b1;
          if (mem_we === 1'b1) begin
            obs_wdata = mem_wdata;
            mem[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr];
          end
        end else begin
          wl--;
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      lat++;
    end
    instr_valid = 1'b0;

    n_checks++;
    if (!done_seen) begin
      $display("FAIL done_timeout op=%0d: no done within 64 cycles", op);
      void'(sb.pop_front());
      return;
    end
    n_pass++;

    got = sb.pop_front();
    n_checks++;
    if (lat !== got.lat) $display("FAIL latency op=%0d: got %0d want %0d", op, lat, got.lat);
    else n_pass++;
    n_checks++;
    if (ac_out !== got.ac) $display("FAIL ac op=%0d: got %h want %h", op, ac_out, got.ac);
    else n_pass++;
    n_checks++;
    if (e_out !== got.e) $display("FAIL e op=%0d: got %b want %b", op, e_out, got.e);
    else n_pass++;
    if (op == OP_STA) begin
      n_checks++;
      if (obs_wdata !== sta_exp) $display("FAIL sta_wdata: got %h want %h", obs_wdata, sta_exp);
      else n_pass++;
    end
    n_checks++;
    if (obs_we_low) $display("FAIL mem_we_level op=%0d: got wrong mem_we during request want %b", op, op == OP_STA);
    else n_pass++;

    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || instr_ready !== 1'b1)
      $display("FAIL post_done op=%0d: got done=%b ready=%b want 0/1", op, done, instr_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (instr_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_ctrl: got rdy=%b req=%b we=%b done=%b want 1/0/0/0",
               instr_ready, mem_req, mem_we, done);
    else n_pass++;
    n_checks++;
    if (ac_out !== 8'h00 || e_out !== 1'b0 || alu_dr !== 8'h00 || alu_sel !== 3'b000)
      $display("FAIL reset_data: got ac=%h e=%b dr=%h sel=%0d want 0", ac_out, e_out, alu_dr, alu_sel);
    else n_pass++;
    m_ac = 8'h00; m_e = 1'b0;
  endtask

  task automatic test_add_zero_wait();
    mem[8'h20] = 8'h37; mem[8'h21] = 8'h05;
    run_instr(OP_LDA, 8'h20, 0, 0);
    n_checks++;
    if (obs_req_cycles !== 1) $display("FAIL lda_req_cycles: got %0d want 1", obs_req_cycles);
    else n_pass++;
    run_instr(OP_ADD, 8'h21, 0, 0);
    n_checks++;
    if (ac_out !== 8'h3C || e_out !== 1'b0) $display("FAIL add_basic: got %h/%b want 3c/0", ac_out, e_out);
    else n_pass++;
    n_checks++;
    if (obs_sel_cycles !== 0) $display("FAIL add_sel: got %0d nonzero sel cycles want 0", obs_sel_cycles);
    else n_pass++;
  endtask

  task automatic test_add_wait_states();
    mem[8'h22] = 8'hFF; mem[8'h23] = 8'h01;
    run_instr(OP_LDA, 8'h22, 0, 0);
    run_instr(OP_ADD, 8'h23, 4, 0);
    n_checks++;
    if (ac_out !== 8'h00 || e_out !== 1'b1) $display("FAIL add_carry: got %h/%b want 00/1", ac_out, e_out);
    else n_pass++;
    n_checks++;
    if (obs_req_cycles !== 5 || obs_addr_moved)
      $display("FAIL add_wait_req: got %0d cycles moved=%b want 5/0", obs_req_cycles, obs_addr_moved);
    else n_pass++;
  endtask

  task automatic test_sub();
    mem[8'h24] = 8'h30; mem[8'h25] = 8'h06; mem[8'h26] = 8'h40;
    run_instr(OP_LDA, 8'h24, 0, 0);
    run_instr(OP_SUB, 8'h25, 1, 0);
    n_checks++;
    if (ac_out !== 8'h2A || e_out !== 1'b1) $display("FAIL sub_ge: got %h/%b want 2a/1", ac_out, e_out);
    else n_pass++;
    n_checks++;
    if (obs_sel_cycles !== 1) $display("FAIL sub_sel: got %0d sel cycles want 1", obs_sel_cycles);
    else n_pass++;
    run_instr(OP_SUB, 8'h26, 0, 0);
    n_checks++;
    if (ac_out !== 8'hEA || e_out !== 1'b0) $display("FAIL sub_lt: got %h/%b want ea/0", ac_out, e_out);
    else n_pass++;
  endtask

  task automatic test_unary();
    mem[8'h27] = 8'h6F;
    run_instr(OP_LDA, 8'h27, 0, 0);
    run_instr(OP_SHL, 8'h00, 0, 0);
    n_checks++;
    if (ac_out !== 8'hDE || e_out !== 1'b0) $display("FAIL shl1: got %h/%b want de/0", ac_out, e_out);
    else n_pass++;
    n_checks++;
    if (obs_req_cycles !== 0 || obs_sel_cycles !== 1)
      $display("FAIL shl_ctrl: got req=%0d sel=%0d want 0/1", obs_req_cycles, obs_sel_cycles);
    else n_pass++;
    run_instr(OP_SHL, 8'h00, 0, 0);
    n_checks++;
    if (ac_out !== 8'hBC || e_out !== 1'b1) $display("FAIL shl2: got %h/%b want bc/1", ac_out, e_out);
    else n_pass++;
    run_instr(OP_CMA, 8'h00, 0, 0);
    n_checks++;
    if (ac_out !== 8'h43 || e_out !== 1'b1) $display("FAIL cma: got %h/%b want 43/1", ac_out, e_out);
    else n_pass++;
    run_instr(OP_CLA, 8'h00, 0, 0);
    n_checks++;
    if (ac_out !== 8'h00 || e_out !== 1'b0) $display("FAIL cla: got %h/%b want 00/0", ac_out, e_out);
    else n_pass++;
  endtask

  task automatic test_store_hold_valid();
    mem[8'h28] = 8'h5E; mem[8'h10] = 8'h00;
    run_instr(OP_LDA, 8'h28, 0, 0);
    run_instr(OP_STA, 8'h10, 2, 1);
    n_checks++;
    if (mem[8'h10] !== 8'h5E) $display("FAIL sta_mem: got %h want 5e", mem[8'h10]);
    else n_pass++;
    n_checks++;
    if (obs_req_cycles !== 3 || obs_addr_moved)
      $display("FAIL sta_req: got %0d cycles moved=%b want 3/0", obs_req_cycles, obs_addr_moved);
    else n_pass++;
    n_checks++;
    if (obs_busy_ready !== 0) $display("FAIL busy_ready: got %0d ready cycles want 0", obs_busy_ready);
    else n_pass++;
    n_checks++;
    if (ac_out !== 8'h5E) $display("FAIL held_valid_reaccepted: got ac=%h want 5e", ac_out);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom_range(0, 255));
      run_instr(op, a, int'($urandom_range(0, 3)), 0);
    end
  endtask

  task automatic test_reset_mid_access();
    mem[8'h30] = 8'h11;
    instr_valid = 1'b1; instr_op = OP_ADD; instr_addr = 8'h30;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (mem_req !== 1'b1) $display("FAIL rst_pre_req: got %b want 1", mem_req);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'h11;
    n_checks++;
    if (mem_req !== 1'b0 || ac_out !== 8'h00 || e_out !== 1'b0 || instr_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL rst_mid: got req=%b ac=%h e=%b rdy=%b done=%b want 0/00/0/1/0",
               mem_req, ac_out, e_out, instr_ready, done);
    else n_pass++;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (done !== 1'b0 || mem_req !== 1'b0 || alu_dr !== 8'h00 || instr_ready !== 1'b1)
        $display("FAIL rst_ack_ignored c%0d: got done=%b req=%b dr=%h rdy=%b want 0/0/00/1",
                 k, done, mem_req, alu_dr, instr_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    m_ac = 8'h00; m_e = 1'b0;
    mem[8'h31] = 8'hA5;
    run_instr(OP_LDA, 8'h31, 1, 0);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_addr = '0;
    mem_rdata = 8'h00; mem_ack = 1'b0;
    m_ac = 8'h00; m_e = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #1;
    test_reset();
    test_add_zero_wait();
    test_add_wait_states();
    test_sub();
    test_unary();
    test_store_hold_valid();
    test_back_to_back();
    test_reset_mid_access();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_left: got %0d entries want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle accumulator controller that sequences the existing 8-bit ALU (AC/DR/selector -> result).
- Owns the AC and DR registers and the E (carry) flag.
- Accepts one instruction at a time over a valid/ready handshake.
- Fetches operands from, and stores AC to, a memory port with unbounded wait states. Drives the ALU selector and latches the ALU result.

Parameters:
ADDR_W, 8, width of instruction address field and mem_addr.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  instruction present
instr_ready  output  1  controller can accept an instruction (IDLE only)
instr_op  input  3  opcode
instr_addr  input  ADDR_W  operand/store address
mem_req  output  1  memory access request, held until mem_ack
mem_we  output  1  1 = store, 0 = load; valid while mem_req
mem_addr  output  ADDR_W  access address, stable while mem_req
mem_wdata  output  8  store data (AC), stable while mem_req
mem_rdata  input  8  load data, valid in mem_ack cycle
mem_ack  input  1  access complete this cycle
alu_sel  output  3  to ALU selector
alu_ac  output  8  to ALU AC input (= AC register)
alu_dr  output  8  to ALU DR input (= DR register)
alu_result  input  8  ALU result (combinational)
ac_out  output  8  AC register
e_out  output  1  E flag
done  output  1  one-cycle pulse when an instruction retires

Behaviour:
- Opcodes:
  - 000 ADD, 001 SUB, 010 XOR: operand in memory.
  - 011 SHL: AC+AC, no operand.
  - 110 CMA: ~AC, no operand.
  - 111 CLA: ALU yields 0.
  - 100 LDA: AC <= mem.
  - 101 STA: mem <= AC.
- Reset: state=IDLE, AC=0, DR=0, E=0, done=0, mem_req=0, mem_we=0, alu_sel=0, instr_ready=1 in the cycle after rst is sampled high.
- rst mid-access drops mem_req in the next cycle. Any pending ack is then ignored.
- States: IDLE, RD, EXEC, WR, DONE.
- IDLE:
  - instr_ready=1. On instr_valid&&instr_ready, latch op/addr.
  - ADD/SUB/XOR/LDA -> RD. STA -> WR. SHL/CMA/CLA -> EXEC.
- RD:
  - mem_req=1, mem_we=0, mem_addr=latched addr.
  - On mem_ack: LDA loads AC<=mem_rdata and goes to DONE. Other ops load DR<=mem_rdata and go to EXEC.
  - Without mem_ack, stay in RD.
- EXEC (exactly one cycle):
  - alu_sel=latched op; AC<=alu_result -> DONE.
  - E rules:
    - ADD: E <= carry-out of AC+DR.
    - SHL: E <= AC[7].
    - SUB: E <= carry-out of AC+~DR+1, i.e. 1 when AC>=DR unsigned.
    - CLA: E <= 0.
    - XOR, CMA: E unchanged.
- WR:
  - mem_req=1, mem_we=1, mem_wdata=AC, mem_addr=latched addr.
  - On mem_ack -> DONE, otherwise stay.
- DONE: done=1 for one cycle, instr_ready=0 -> IDLE.
- Latency from the accept edge to the done pulse, with zero-wait memory (ack in first RD/WR cycle):
  - ADD/SUB/XOR: 3 cycles.
  - LDA/STA: 2 cycles.
  - SHL/CMA/CLA: 2 cycles.
  - Each extra wait cycle adds 1.
- mem_ack while mem_req=0 is ignored.
- instr_valid outside IDLE is ignored; the instruction is not consumed.
- mem_addr/mem_we/mem_wdata are held stable for the whole request.
- alu_sel is 000 outside EXEC. alu_ac/alu_dr always reflect the registers.
- Arithmetic is 8-bit modulo 256; E captures bit 8.

Decomposition:
- Shared package holds:
  - opcode localparams OP_ADD=3'b000, OP_SUB=3'b001, OP_XOR=3'b010, OP_SHL=3'b011, OP_LDA=3'b100, OP_STA=3'b101, OP_CMA=3'b110, OP_CLA=3'b111;
  - state encoding typedef (IDLE, RD, EXEC, WR, DONE).
- The ALU stays external; the controller contains no arithmetic except the 9-bit E computation.
- No sub-module needed; the FSM and datapath registers live in one module.

Test Plan:
1. LDA 0x37 (zero-wait), then ADD 0x05 -> AC=0x3C, E=0, done 3 cycles after the ADD accept, alu_sel=000 in EXEC only.
2. LDA 0xFF, then ADD 0x01 with 4 wait cycles -> AC=0x00, E=1; mem_req held 5 cycles with a stable address; done 7 cycles after accept.
3. LDA 0x30, SUB 0x06 -> AC=0x2A, E=1. Then SUB 0x40 -> AC=0xEA, E=0.
4. LDA 0x6F, SHL -> AC=0xDE, E=0. SHL again -> AC=0xBC, E=1. CMA -> AC=0x43, E unchanged=1. CLA -> AC=0x00, E=0.
5. LDA 0x5E, STA addr 0x10 -> mem_we=1, mem_wdata=0x5E, mem_addr=0x10 until ack. instr_valid held during the op is not re-accepted; instr_ready=0 until IDLE.
6. Assert rst during the RD wait of an ADD, with ack arriving the cycle after rst -> mem_req=0, AC=0, E=0, state IDLE, no done pulse, ack ignored.
